// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner: column rotation, debounce on press and
// release, and a single key_valid strobe per debounced press.
module key_matrix_scan #(
  parameter int unsigned SCAN_DIV = 50_000,
  parameter int unsigned DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DB_TICKS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t           state, state_n;
  logic [3:0]       rs_meta, rs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       cand_row, cand_row_n;
  logic [1:0]       cand_col, cand_col_n;
  logic [3:0]       cand_pat, cand_pat_n;
  logic [CNT_W-1:0] db_cnt, db_cnt_n;
  logic [CNT_W-1:0] rel_cnt, rel_cnt_n;
  logic             key_valid_n, key_down_n;
  logic [3:0]       key_code_n;
  logic [3:0]       row_low;
  logic             single_low;
  logic [1:0]       row_enc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta <= '1;
      rs      <= '1;
      div_cnt <= '0;
    end else begin
      rs_meta <= row_in;
      rs      <= rs_meta;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign col_out = ~(4'b0001 << col_idx);

  // Exactly one row low means a single unambiguous key on the driven column.
  always_comb begin
    row_low    = ~rs;
    single_low = (row_low != '0) && ((row_low & (row_low - 4'd1)) == '0);
    row_enc    = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (row_low[i]) row_enc = 2'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      cand_pat  <= '1;
      db_cnt    <= '0;
      rel_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      cand_row  <= cand_row_n;
      cand_col  <= cand_col_n;
      cand_pat  <= cand_pat_n;
      db_cnt    <= db_cnt_n;
      rel_cnt   <= rel_cnt_n;
      key_valid <= key_valid_n;
      key_code  <= key_code_n;
      key_down  <= key_down_n;
    end
  end

  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    cand_row_n  = cand_row;
    cand_col_n  = cand_col;
    cand_pat_n  = cand_pat;
    db_cnt_n    = db_cnt;
    rel_cnt_n   = rel_cnt;
    key_valid_n = 1'b0;
    key_code_n  = key_code;
    key_down_n  = key_down;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (single_low) begin
            cand_row_n = row_enc;
            cand_col_n = col_idx;
            cand_pat_n = rs;
            db_cnt_n   = CNT_W'(1);
            if (DB_TICKS == 1) begin
              db_cnt_n    = '0;
              key_valid_n = 1'b1;
              key_code_n  = {row_enc, col_idx};
              key_down_n  = 1'b1;
              state_n     = PRESSED;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rs == cand_pat) begin
            if (db_cnt + 1'b1 == CNT_W'(DB_TICKS)) begin
              db_cnt_n    = '0;
              key_valid_n = 1'b1;
              key_code_n  = {cand_row, cand_col};
              key_down_n  = 1'b1;
              state_n     = PRESSED;
            end else begin
              db_cnt_n = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_n  = '0;
            col_idx_n = col_idx + 2'd1;
            state_n   = SCAN;
          end
        end
        PRESSED: begin
          if (rs == 4'hF) begin
            if (rel_cnt + 1'b1 == CNT_W'(DB_TICKS)) begin
              rel_cnt_n  = '0;
              key_down_n = 1'b0;
              col_idx_n  = col_idx + 2'd1;
              state_n    = SCAN;
            end else begin
              rel_cnt_n = rel_cnt + 1'b1;
            end
          end else begin
            rel_cnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan with a behavioural 4x4 keypad model.
module tb_key_matrix_scan;

  localparam int unsigned TICK = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code  = '0;

  key_matrix_scan #(.SCAN_DIV(4), .DB_TICKS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row r is pulled low when a closed key (r,c) sits on the driven column c.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Strobe shape, key_down alignment and key_code stability watched throughout.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        pulses++;
        check("valid_width", int'(prev_valid), 0);
        check("down_with_valid", int'(key_down), 1);
      end
      if (!key_valid && key_code != prev_code)
        check("code_changed_without_valid", int'(key_code), int'(prev_code));
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] keys;
    int          ticks;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_down;
    logic        chk_rot;
  } vec_t;

  vec_t vec [5];
  int   base;
  logic [3:0] c0;

  initial begin
    vec[0] = '{16'h0200,   40, 1, 4'd9,  1'b1, 1'b0};  // key (2,1)
    vec[1] = '{16'h1000, 1000, 1, 4'd12, 1'b1, 1'b0};  // key (3,0) long hold
    vec[2] = '{16'h4004,   50, 0, 4'd0,  1'b0, 1'b1};  // ghost (0,2)+(3,2)
    vec[3] = '{16'h8000,   40, 1, 4'd15, 1'b1, 1'b0};  // key (3,3)
    vec[4] = '{16'h0040,    2, 0, 4'd0,  1'b0, 1'b0};  // (1,2) too short

    keys  = '0;
    rst_n = 1'b0;
    wait_clk(3);
    check("rst_col_out", int'(col_out), 4'b1110);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_down", int'(key_down), 0);
    rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      check("rotation", int'(col_out), int'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
      @(negedge clk);
    end

    for (int i = 0; i < 5; i++) begin
      keys = '0;
      do_reset();
      base = pulses;
      keys = vec[i].keys;
      wait_clk(vec[i].ticks * TICK);
      check("vec_pulses", pulses - base, vec[i].exp_pulses);
      check("vec_code", int'(key_code), int'(vec[i].exp_code));
      check("vec_down", int'(key_down), int'(vec[i].exp_down));
      if (vec[i].chk_rot) begin
        c0 = col_out;
        wait_clk(TICK);
        check("ghost_rotates", int'(col_out != c0), 1);
      end
    end

    // Release timing of key (2,1)
    keys = '0;
    do_reset();
    base = pulses;
    keys = 16'h0200;
    wait_clk(40 * TICK);
    check("rel_pulse", pulses - base, 1);
    keys = '0;
    wait_clk(10);
    check("rel_down_held", int'(key_down), 1);
    wait_clk(4);
    check("rel_down_fell", int'(key_down), 0);
    wait_clk(20 * TICK);
    check("rel_no_extra", pulses - base, 1);

    // Bouncing key (0,3): alternate ticks, then stable
    do_reset();
    base = pulses;
    for (int t = 0; t < 12; t++) begin
      keys = (t % 2 == 0) ? 16'h0008 : 16'h0000;
      wait_clk(TICK);
    end
    check("bounce_no_pulse", pulses - base, 0);
    keys = 16'h0008;
    wait_clk(40 * TICK);
    check("bounce_pulse", pulses - base, 1);
    check("bounce_code", int'(key_code), 3);

    // Reset in the middle of PRESSED with key (1,1) held
    keys = '0;
    do_reset();
    base = pulses;
    keys = 16'h0020;
    wait_clk(40 * TICK);
    check("mid_first_pulse", pulses - base, 1);
    check("mid_first_code", int'(key_code), 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_down", int'(key_down), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_col", int'(col_out), 4'b1110);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(40 * TICK);
    check("mid_second_pulse", pulses - base, 2);
    check("mid_second_code", int'(key_code), 5);
    check("mid_second_down", int'(key_down), 1);
    keys = '0;
    wait_clk(20 * TICK);
    check("mid_no_extra", pulses - base, 2);
    check("mid_released", int'(key_down), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
